// File: rtl/array_loader.sv
// array_loader
//   Receives a byte stream over a valid/ready handshake and fills a
//   ROWS x COLS byte array in row-major order. Bytes land in a shadow array.
//   When a complete, correctly terminated frame arrives, the shadow array is
//   copied atomically to the visible array. Short frames and over-long frames
//   are discarded, and the visible array is left untouched.
//
// Parameters
//   ROWS, COLS  array geometry (each >= 1)
//   DESC_ORDER  0: stream byte k -> column k mod COLS
//               1: stream byte k -> column COLS-1-(k mod COLS)
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   in_valid/in_data/in_last byte stream input, in_last marks the frame end
//   in_ready                 registered; high while the loader accepts bytes
//   rd_row/rd_col/rd_data    registered read of the visible array (1 cycle);
//                            out-of-range indices read 0x00
//   frame_done / frame_err   one-cycle pulses on frame commit / discard
//   rec_a_out                set once any frame has committed since reset
//   rec_b_out                XOR of all bytes of the last committed frame
//   frame_cnt                (only with ARRAY_LOADER_FRAME_COUNT_EN) count of
//                            committed frames, wrapping at 8 bits
//
// Build option
//   `define ARRAY_LOADER_FRAME_COUNT_EN adds the frame_cnt output and counter.
module array_loader #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DESC_ORDER = 0,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [7:0]    rd_data,
    output logic          frame_done,
    output logic          frame_err,
    output logic          rec_a_out,
`ifdef ARRAY_LOADER_FRAME_COUNT_EN
    output logic [7:0]    frame_cnt,
`endif
    output logic [7:0]    rec_b_out
);

    localparam int N  = ROWS * COLS;
    localparam int NW = $clog2(N + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMMIT, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] cnt_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] wr_col;
    logic [7:0]    xor_q;
    logic [7:0]    shadow_q  [ROWS][COLS];
    logic [7:0]    visible_q [ROWS][COLS];
    logic          in_ready_q, frame_done_q, frame_err_q, rec_a_q;
    logic [7:0]    rec_b_q, rd_data_q;
    logic          xfer, wr_en, last_slot, rd_hit;

    assign xfer      = in_valid && in_ready_q;
    // cnt_q is 0 in IDLE, so this also covers the single-element array case.
    assign last_slot = (cnt_q == NW'(N - 1));
    assign wr_col    = (DESC_ORDER != 0) ? (CW'(COLS - 1) - col_q) : col_q;
    assign rd_hit    = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        unique case (state_q)
            S_IDLE, S_LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (in_last)        state_d = last_slot ? S_COMMIT : S_ERR;
                    // Array full but no terminator yet: swallow the excess.
                    else if (last_slot) state_d = S_DRAIN;
                    else                state_d = S_LOAD;
                end
            end
            S_DRAIN:  if (xfer && in_last) state_d = S_ERR;
            S_COMMIT: state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rec_a_q      <= 1'b0;
            rec_b_q      <= 8'h00;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            xor_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            // Registered decode of the upcoming state, so ready never
            // depends combinationally on in_valid.
            in_ready_q   <= (state_d == S_IDLE) || (state_d == S_LOAD) ||
                            (state_d == S_DRAIN);
            frame_done_q <= (state_q == S_COMMIT);
            frame_err_q  <= (state_q == S_ERR);
            if (state_q == S_COMMIT) begin
                rec_a_q <= 1'b1;
                rec_b_q <= xor_q;
            end
            if (state_q == S_COMMIT || state_q == S_ERR) begin
                cnt_q <= '0;
                row_q <= '0;
                col_q <= '0;
            end else if (wr_en) begin
                cnt_q <= cnt_q + 1'b1;
                xor_q <= (state_q == S_IDLE) ? in_data : (xor_q ^ in_data);
                if (col_q == CW'(COLS - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    shadow_q[r][c]  <= 8'h00;
                    visible_q[r][c] <= 8'h00;
                end
            end
            rd_data_q <= 8'h00;
        end else begin
            if (wr_en) shadow_q[row_q][wr_col] <= in_data;
            if (state_q == S_COMMIT) visible_q <= shadow_q;
            // Reads the old visible contents on the commit edge.
            rd_data_q <= rd_hit ? visible_q[rd_row][rd_col] : 8'h00;
        end
    end

`ifdef ARRAY_LOADER_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                    frame_cnt_q <= 8'h00;
        else if (state_q == S_COMMIT) frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign in_ready   = in_ready_q;
    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign rec_a_out  = rec_a_q;
    assign rec_b_out  = rec_b_q;

endmodule

// File: tb/tb_array_loader.sv
module tb_array_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_last;
    logic [7:0] in_data;
    logic [1:0] rd_row, rd_col;

    logic       in_ready, frame_done, frame_err, rec_a_out;
    logic [7:0] rd_data, rec_b_out;
    logic       in_ready_d, frame_done_d, frame_err_d, rec_a_out_d;
    logic [7:0] rd_data_d, rec_b_out_d;
`ifdef ARRAY_LOADER_FRAME_COUNT_EN
    logic [7:0] frame_cnt, frame_cnt_d;
`endif

    always #5 clk = ~clk;

    array_loader #(.ROWS(4), .COLS(4), .DESC_ORDER(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .frame_done(frame_done), .frame_err(frame_err),
        .rec_a_out(rec_a_out),
`ifdef ARRAY_LOADER_FRAME_COUNT_EN
        .frame_cnt(frame_cnt),
`endif
        .rec_b_out(rec_b_out)
    );

    array_loader #(.ROWS(4), .COLS(4), .DESC_ORDER(1)) dut_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_d), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data_d), .frame_done(frame_done_d), .frame_err(frame_err_d),
        .rec_a_out(rec_a_out_d),
`ifdef ARRAY_LOADER_FRAME_COUNT_EN
        .frame_cnt(frame_cnt_d),
`endif
        .rec_b_out(rec_b_out_d)
    );

    int total = 0;
    int bad   = 0;
    int stalls = 0;
    int commits = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] xv;
    } ev_t;
    ev_t evq[$];

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [7:0] ea;
        logic [7:0] ed;
    } rd_vec_t;
    rd_vec_t tbl[6];

    logic [7:0] exp_a [4][4];
    logic [7:0] exp_d [4][4];
    logic [7:0] last_xor = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp_a[r][c] = 8'h00;
                exp_d[r][c] = 8'h00;
            end
        last_xor = 8'h00;
    endtask

    // Drive one byte; returns right after the edge that transfers it.
    task automatic send(input logic [7:0] b, input bit last);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready) begin
            stalls++;
            w++;
            if (w > 20) begin
                $display("FAIL send_timeout: in_ready stuck at %0b", in_ready);
                $fatal(1, "bench stopped");
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bs[$], input bit keep);
        int n;
        logic [7:0] x;
        n = bs.size();
        x = 8'h00;
        for (int i = 0; i < n && i < 16; i++) x ^= bs[i];
        if (n == 16) begin
            evq.push_back(ev_t'{1'b0, x});
            for (int k = 0; k < 16; k++) begin
                exp_a[k / 4][k % 4]     = bs[k];
                exp_d[k / 4][3 - k % 4] = bs[k];
            end
            last_xor = x;
            commits++;
        end else begin
            evq.push_back(ev_t'{1'b1, 8'h00});
        end
        for (int i = 0; i < n; i++) send(bs[i], (i == n - 1));
        if (!keep) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic rd(input logic [1:0] r, input logic [1:0] c,
                      output logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_row = r;
        rd_col = c;
        @(negedge clk);
        a = rd_data;
        d = rd_data_d;
    endtask

    task automatic check_all(input string name);
        logic [7:0] a, d;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                rd(r[1:0], c[1:0], a, d);
                chk({name, "_asc"}, a, exp_a[r][c]);
                chk({name, "_desc"}, d, exp_d[r][c]);
            end
    endtask

    task automatic check_table(input string name);
        logic [7:0] a, d;
        for (int i = 0; i < 6; i++) begin
            rd(tbl[i].r, tbl[i].c, a, d);
            chk({name, "_asc"}, a, tbl[i].ea);
            chk({name, "_desc"}, d, tbl[i].ed);
        end
    endtask

    // Scoreboard: every pulse must match the next expected frame outcome.
    always @(negedge clk) begin
        ev_t ev;
        if (!reset && (frame_done || frame_err || frame_done_d || frame_err_d)) begin
            chk("desc_done_match", frame_done_d, frame_done);
            chk("desc_err_match", frame_err_d, frame_err);
            if (frame_done || frame_err) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", {frame_done, frame_err}, 2'b00);
                end else begin
                    ev = evq.pop_front();
                    chk("pulse_err", frame_err, ev.is_err);
                    chk("pulse_done", frame_done, !ev.is_err);
                    if (!ev.is_err) begin
                        chk("rec_b", rec_b_out, ev.xv);
                        chk("rec_b_desc", rec_b_out_d, ev.xv);
                        chk("rec_a", rec_a_out, 1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "bench stopped");
    end

    initial begin
        logic [7:0] bs[$];
        logic [7:0] a, d;

        tbl[0] = '{2'd2, 2'd1, 8'h09, 8'h0A};
        tbl[1] = '{2'd0, 2'd0, 8'h00, 8'h03};
        tbl[2] = '{2'd0, 2'd3, 8'h03, 8'h00};
        tbl[3] = '{2'd3, 2'd0, 8'h0C, 8'h0F};
        tbl[4] = '{2'd3, 2'd3, 8'h0F, 8'h0C};
        tbl[5] = '{2'd1, 2'd2, 8'h06, 8'h05};

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        rd_row = 2'd0; rd_col = 2'd0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rec_a", rec_a_out, 0);
        chk("rst_rec_b", rec_b_out, 0);
        reset = 1'b0;
        rd(2'd2, 2'd2, a, d);
        chk("rst_visible", a, 0);

        // Frame 0x00..0x0F, with exact pulse timing and commit-edge read.
        bs = {};
        for (int i = 0; i < 16; i++) bs.push_back(i[7:0]);
        rd_row = 2'd2; rd_col = 2'd1;
        send_frame(bs, 1'b0);
        chk("t_done_early", frame_done, 0);
        chk("t_ready_commit", in_ready, 0);
        @(negedge clk);
        chk("t_done_pulse", frame_done, 1);
        chk("t_rd_precommit", rd_data, 8'h00);
        @(negedge clk);
        chk("t_done_clear", frame_done, 0);
        chk("t_rd_postcommit", rd_data, 8'h09);
        chk("t_rec_a", rec_a_out, 1);
        chk("t_rec_b", rec_b_out, 8'h00);
        check_table("asc_frame");

        // Short frame: discarded.
        bs = {};
        repeat (5) bs.push_back(8'hAA);
        send_frame(bs, 1'b0);
        repeat (3) @(negedge clk);
        chk("short_rec_b", rec_b_out, last_xor);
        check_table("short_keep");

        // Long frame: DRAIN keeps ready high, then discarded.
        bs = {};
        repeat (16) bs.push_back(8'h11);
        repeat (3) bs.push_back(8'h22);
        stalls = 0;
        send_frame(bs, 1'b0);
        chk("long_no_stall", stalls, 0);
        repeat (3) @(negedge clk);
        chk("long_rec_b", rec_b_out, last_xor);
        check_table("long_keep");

        // Back-to-back frames with valid held high throughout.
        stalls = 0;
        bs = {};
        for (int i = 0; i < 16; i++) bs.push_back(8'((i * 3 + 1) ^ 8'h5A));
        send_frame(bs, 1'b1);
        bs = {};
        for (int i = 0; i < 16; i++) bs.push_back(8'($urandom_range(0, 255)));
        send_frame(bs, 1'b0);
        chk("bp_one_stall", stalls, 1);
        repeat (3) @(negedge clk);
        chk("bp_rec_b", rec_b_out, last_xor);
        check_all("bp_frame");

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send(8'hE0 + i[7:0], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_rec_a", rec_a_out, 0);
        chk("mid_rst_rec_b", rec_b_out, 0);
        bs = {};
        for (int i = 0; i < 8; i++) bs.push_back(8'h80 + i[7:0]);
        send_frame(bs, 1'b0);
        bs = {};
        for (int i = 0; i < 16; i++) bs.push_back(8'hC3 ^ i[7:0]);
        model_clear();
        send_frame(bs, 1'b0);
        repeat (3) @(negedge clk);
        check_all("after_rst");

        repeat (4) @(negedge clk);
        chk("queue_empty", evq.size(), 0);
`ifdef ARRAY_LOADER_FRAME_COUNT_EN
        chk("frame_cnt", frame_cnt, 8'(commits - 3));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
